// File: rtl/mac4_pkg.sv
// Shared types and defaults for the 4-bit multiply-accumulate stage.
package mac4_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int N_DEF     = 4;
    localparam int ACC_W_DEF = 10;

    // Pair counter must be able to hold N itself after the last accept.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/multi4.sv
// 4x4 unsigned combinational multiplier.
module multi4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    assign p = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/mac4_acc.sv
// Multiply-accumulate stage: sums N products of 4-bit operand pairs and hands
// the dot product downstream through a valid/ready handshake.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_ACC   | accepting operand pairs, accumulating registered products
//   ST_DRAIN | last pair accepted; its product is added this cycle
//   ST_DONE  | result presented on acc_out/ovf until out_ready
module mac4_acc
    import mac4_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);

    localparam int            CW       = cnt_w(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        prod;
    logic [7:0]        p_reg;
    logic              p_vld;
    logic [CW-1:0]     cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W:0]    sum;
    logic              accept;
    logic              take;

    multi4 u_mul (
        .a (a),
        .b (b),
        .p (prod)
    );

    // clr wins over an offered pair, so it must gate the accept itself.
    assign accept  = in_valid & in_ready & ~clr;
    assign take    = out_valid & out_ready;
    assign sum     = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, p_reg};
    assign acc_out = acc;

    // State register; rst and clr both return to ST_ACC.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:   if (accept && (cnt == CNT_LAST)) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  if (take) state_nxt = ST_ACC;
            default:  state_nxt = ST_ACC;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_ACC:  in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Product pipeline register, pair counter, accumulator and sticky carry.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            p_reg <= '0;
            p_vld <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
        end else begin
            p_vld <= accept;
            if (accept) begin
                p_reg <= prod;
                cnt   <= cnt + CW'(1);
            end
            // A handshake only happens in ST_DONE, where no product is pending.
            if (take) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else if (p_vld) begin
                acc <= sum[ACC_W-1:0];
                if (sum[ACC_W]) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac4_acc.sv
// Directed bench for mac4_acc: three instances (N=4/ACC_W=10, N=4/ACC_W=8,
// N=1/ACC_W=10) share stimulus; each section observes one of them.
module tb_mac4_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_ready;

    logic       ir_0, ov_0, of_0;
    logic [9:0] acc_0;
    logic       ir_8, ov_8, of_8;
    logic [7:0] acc_8;
    logic       ir_1, ov_1, of_1;
    logic [9:0] acc_1;

    logic [1:0]  sel;
    logic        o_in_ready;
    logic        o_out_valid;
    logic        o_ovf;
    logic [15:0] o_acc;

    int n_cmp = 0;
    int n_err = 0;

    mac4_acc #(.N(4), .ACC_W(10)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir_0),
        .a(a), .b(b), .out_valid(ov_0), .out_ready(out_ready),
        .acc_out(acc_0), .ovf(of_0)
    );

    mac4_acc #(.N(4), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir_8),
        .a(a), .b(b), .out_valid(ov_8), .out_ready(out_ready),
        .acc_out(acc_8), .ovf(of_8)
    );

    mac4_acc #(.N(1), .ACC_W(10)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(ir_1),
        .a(a), .b(b), .out_valid(ov_1), .out_ready(out_ready),
        .acc_out(acc_1), .ovf(of_1)
    );

    always #5 clk = ~clk;

    // Route the instance under observation to the checkers.
    always_comb begin
        case (sel)
            2'd1: begin
                o_in_ready = ir_8; o_out_valid = ov_8; o_ovf = of_8; o_acc = 16'(acc_8);
            end
            2'd2: begin
                o_in_ready = ir_1; o_out_valid = ov_1; o_ovf = of_1; o_acc = 16'(acc_1);
            end
            default: begin
                o_in_ready = ir_0; o_out_valid = ov_0; o_ovf = of_0; o_acc = 16'(acc_0);
            end
        endcase
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_state(input string tag);
        chk({tag, " in_ready"},  16'(o_in_ready),  16'd1);
        chk({tag, " out_valid"}, 16'(o_out_valid), 16'd0);
        chk({tag, " acc_out"},   o_acc,            16'd0);
        chk({tag, " ovf"},       16'(o_ovf),       16'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; a = 4'd0; b = 4'd0;
        tick(); tick();
        idle_state("reset");
        rst = 1'b0;
    endtask

    // Offer one pair for a single cycle; the observed instance must accept it.
    task automatic send_pair(input logic [3:0] x, input logic [3:0] y);
        a = x; b = y; in_valid = 1'b1;
        chk("accept in_ready", 16'(o_in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Called in the cycle after the last accept, with out_ready high.
    task automatic finish_dp(input string tag, input logic [15:0] exp_acc, input logic exp_ovf);
        chk({tag, " drain in_ready"},  16'(o_in_ready),  16'd0);
        chk({tag, " drain out_valid"}, 16'(o_out_valid), 16'd0);
        tick();
        chk({tag, " out_valid"}, 16'(o_out_valid), 16'd1);
        chk({tag, " acc_out"},   o_acc,            exp_acc);
        chk({tag, " ovf"},       16'(o_ovf),       16'(exp_ovf));
        tick();
        idle_state({tag, " after take"});
    endtask

    initial begin
        sel = 2'd0; out_ready = 1'b0;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; a = 4'd0; b = 4'd0;

        // Basic back-to-back sum: 15 + 225 + 0 + 14 = 254.
        do_reset();
        out_ready = 1'b1;
        send_pair(4'd3, 4'd5);
        send_pair(4'd15, 4'd15);
        send_pair(4'd0, 4'd9);
        send_pair(4'd7, 4'd2);
        finish_dp("basic", 16'd254, 1'b0);

        // Gapped input, then 5 stalled DONE cycles with a pair offered.
        do_reset();
        out_ready = 1'b0;
        send_pair(4'd3, 4'd5);  tick(); tick();
        send_pair(4'd15, 4'd15); tick(); tick();
        send_pair(4'd0, 4'd9);  tick(); tick();
        chk("gap acc_out", o_acc, 16'd240);
        send_pair(4'd7, 4'd2);
        chk("bp drain in_ready", 16'(o_in_ready), 16'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 4); a = 4'd1; b = 4'd1;
            chk("bp out_valid", 16'(o_out_valid), 16'd1);
            chk("bp acc_out",   o_acc,            16'd254);
            chk("bp in_ready",  16'(o_in_ready),  16'd0);
            if (i == 4) out_ready = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        idle_state("bp after take");
        // 2 + 4 + 9 + 4 = 19, must start from zero.
        send_pair(4'd1, 4'd2);
        send_pair(4'd2, 4'd2);
        send_pair(4'd3, 4'd3);
        send_pair(4'd4, 4'd1);
        finish_dp("bp next", 16'd19, 1'b0);

        // Overflow with ACC_W=8: 900 mod 256 = 132.
        sel = 2'd1;
        do_reset();
        out_ready = 1'b1;
        repeat (4) send_pair(4'd15, 4'd15);
        finish_dp("ovf", 16'd132, 1'b1);
        repeat (4) send_pair(4'd1, 4'd1);
        finish_dp("ovf next", 16'd4, 1'b0);

        // clr after two accepts, with a pair offered in the same cycle.
        sel = 2'd0;
        do_reset();
        send_pair(4'd1, 4'd1);
        send_pair(4'd1, 4'd1);
        clr = 1'b1; in_valid = 1'b1; a = 4'd9; b = 4'd9;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        tick();
        idle_state("clr");
        repeat (4) send_pair(4'd2, 4'd3);
        finish_dp("clr next", 16'd24, 1'b0);

        // rst while DONE is stalled with a sticky carry.
        sel = 2'd1;
        do_reset();
        out_ready = 1'b0;
        repeat (4) send_pair(4'd15, 4'd15);
        tick();
        chk("rst pre out_valid", 16'(o_out_valid), 16'd1);
        chk("rst pre ovf",       16'(o_ovf),       16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_state("rst done");

        // Every product through the N=1 instance.
        sel = 2'd2;
        do_reset();
        out_ready = 1'b1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                send_pair(4'(x), 4'(y));
                finish_dp("n1", 16'(x * y), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac4_acc.md
# mac4_acc

Sequential multiply-accumulate stage directly downstream of the 4x4 unsigned multiplier `multi4`. It accepts a stream of 4-bit operand pairs through a valid/ready handshake and forms each product with one `multi4` instance. It sums N products into a dot-product result and presents that result through a second valid/ready handshake. It is the consumer that turns `multi4`'s combinational product into a registered, flow-controlled accumulation.

## Interface
- `N`, 4: operand pairs per dot product; legal range 1..16.
- `ACC_W`, 10: accumulator width; legal range 8..16. Default covers 4 × 225 = 900 without wrap.
- `clk` input 1: rising-edge clock.
- `rst` input 1: reset, synchronous and active-high.
- `clr` input 1: synchronous abort and clear of the current dot product.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block can accept a pair.
- `a` input 4: unsigned operand.
- `b` input 4: unsigned operand.
- `out_valid` output 1: `acc_out` holds a finished dot product.
- `out_ready` input 1: downstream accepts the result.
- `acc_out` output ACC_W: dot-product sum, modulo 2^ACC_W.
- `ovf` output 1: a carry out of ACC_W occurred during this dot product.

## Operation
- **States:** ACC, DRAIN, DONE. Reset state is ACC.
- **Control outputs:** `in_ready` = (state == ACC). `out_valid` = (state == DONE).
- **Accept:** a pair is accepted when `in_valid & in_ready`. On accept:
  - `p_reg` <= `multi4(a,b)` (8-bit).
  - `p_vld` <= 1.
  - `cnt` <= `cnt` + 1.
  - With no accept, `p_vld` <= 0.
- **Accumulate:** when `p_vld`, `acc` <= `acc` + zero-extended `p_reg`, truncated to ACC_W. A carry out of ACC_W sets `ovf`, which is sticky until the result is taken.
- **ACC → DRAIN:** when the accepted pair is the Nth (`cnt == N-1` at accept).
- **DRAIN → DONE:** unconditional after one cycle; the final product is added in that cycle.
- **DONE:** `acc_out` and `ovf` are held stable while `out_ready` is low. On `out_valid & out_ready`:
  - `acc`, `cnt` and `ovf` <= 0.
  - State <= ACC.
- **Gaps:** `in_valid` may deassert between pairs; `cnt` and `acc` hold.
- **`clr`:** has priority over all activity except `rst`. It forces:
  - `acc`, `cnt`, `ovf`, `p_vld` <= 0.
  - State <= ACC.
  - The in-flight product is discarded, and an input offered in the same cycle is not accepted.
- **`rst`:** has the same effect as `clr`, with top priority. It is valid in any state, including mid-accumulation or while DONE is stalled.
- **Reset values of outputs:**
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `acc_out` = 0.
  - `ovf` = 0.
- **Direct output:** `acc_out` is driven directly from `acc`.

## Timing
- **Product latency:** a product is accepted at cycle k and added to `acc` at the edge ending cycle k+1.
- **Result latency:** the Nth pair is accepted in cycle k. `in_ready` is low from cycle k+1 and `out_valid` is high from cycle k+2.
- **Throughput:**
  - Minimum period is N+2 cycles per dot product when `out_ready` is held high.
  - The result handshake in cycle d gives `in_ready` = 1 in cycle d+1.
  - No input is accepted while DRAIN or DONE.
- **Edge case N=1:** ACC → DRAIN occurs on the first accept.

## Structure
- **Package `mac4_pkg`:**
  - State enum: ACC, DRAIN, DONE.
  - Default constants for N and ACC_W.
  - Count-width function: clog2(N+1).
- **Sub-module:** one instance of the existing `multi4`, used unchanged. All sequential logic lives in `mac4_acc`.

## Test plan
- **Basic sum:** pairs (3,5), (15,15), (0,9), (7,2) back to back, `out_ready` = 1.
  - Required: `acc_out` = 254, `ovf` = 0.
  - `out_valid` high 2 cycles after the 4th accept, for 1 cycle.
  - `in_ready` = 1 on the following cycle.
- **Backpressure and gaps:** same pairs with 2-cycle `in_valid` gaps, then `out_ready` low for 5 cycles.
  - Required: `acc_out` stays 254 and `in_ready` stays 0 throughout.
  - Handshake on the 6th cycle.
  - The next dot product starts from 0.
- **Overflow (ACC_W=8):** four (15,15) pairs.
  - Required: `acc_out` = 132 (900 mod 256), `ovf` = 1.
  - After handshake, a new (1,1)×4 sequence gives 4 with `ovf` = 0.
- **`clr` mid-operation:** assert `clr` after 2 accepted pairs, with `in_valid` high in the same cycle; then feed (2,3)×4.
  - Required: the offered pair is not accepted, and the result is 24.
- **Reset mid-operation:** assert `rst` while in DONE with `out_ready` low.
  - Required next cycle: `out_valid` = 0, `in_ready` = 1, `acc_out` = 0, `ovf` = 0.
- **Exhaustive product (N=1):** all 256 (a,b) pairs.
  - Required: each `acc_out` = a·b, with `ovf` = 0.
